// File: rtl/rst_status_mon_pkg.sv
// rst_status_mon_pkg: shared sequencer state and event record types
package rst_status_mon_pkg;
  localparam int N_STATUS_DEF = 4;
  localparam int TS_WIDTH_DEF = 32;
  typedef enum logic [1:0] {SEQ_HOLD, SEQ_STAGGER, SEQ_RUN} seq_state_e;
  typedef struct packed {
    logic [N_STATUS_DEF-1:0] status;
    logic [TS_WIDTH_DEF-1:0] ts;
  } ev_t;
endpackage

// File: rtl/status_ev_fifo.sv
// status_ev_fifo: synchronous show-ahead FIFO with full/empty flags
module status_ev_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic do_push, do_pop;
  assign empty_o = wr_q == rd_q;
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  // head is forced to zero while empty so outputs read 0 out of reset
  assign dout_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
    end
  end
endmodule

// File: rtl/multicore_rst_status_mon.sv
// multicore_rst_status_mon: staggered core reset sequencer plus timestamped status-change event log
module multicore_rst_status_mon
  import rst_status_mon_pkg::*;
#(
  parameter int N_CORES    = 2,
  parameter int RST_CYCLES = 100,
  parameter int STAGGER    = 16,
  parameter int N_STATUS   = N_STATUS_DEF,
  parameter int TS_WIDTH   = TS_WIDTH_DEF,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_STATUS-1:0] status_i,
  output logic                sys_rstn_o,
  output logic [N_CORES-1:0]  core_rstn_o,
  output logic                ev_valid_o,
  input  logic                ev_ready_i,
  output logic [N_STATUS-1:0] ev_status_o,
  output logic [TS_WIDTH-1:0] ev_ts_o,
  output logic [15:0]         ev_drop_cnt_o
);
  localparam int LAST = RST_CYCLES + (N_CORES - 1) * STAGGER;
  localparam int CW = $clog2(LAST + 2);
  typedef struct packed {
    logic [N_STATUS-1:0] status;
    logic [TS_WIDTH-1:0] ts;
  } ev_rec_t;
  seq_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TS_WIDTH-1:0] ts_q;
  logic [N_STATUS-1:0] status_q;
  logic [15:0] drop_q;
  logic full, empty, push, pop, change;
  ev_rec_t ev_in, ev_out;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEQ_HOLD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    cnt_d   = state_q == SEQ_RUN ? cnt_q : cnt_q + 1'b1;
    state_d = (state_q == SEQ_HOLD && cnt_q == CW'(RST_CYCLES)) ? (LAST == RST_CYCLES ? SEQ_RUN : SEQ_STAGGER)
            : (state_q == SEQ_STAGGER && cnt_q == CW'(LAST)) ? SEQ_RUN : state_q;
  end
  // core k is out of reset once the counter has passed its release count
  always_comb begin
    sys_rstn_o = state_q != SEQ_HOLD;
    for (int k = 0; k < N_CORES; k++)
      core_rstn_o[k] = state_q == SEQ_RUN || (state_q == SEQ_STAGGER && cnt_q > CW'(RST_CYCLES + k * STAGGER));
  end
  assign change = status_i != status_q;
  assign pop    = !empty && ev_ready_i;
  assign push   = change && (!full || pop);
  assign ev_in  = '{status: status_i, ts: ts_q};
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q     <= '0;
      status_q <= '0;
      drop_q   <= '0;
    end else begin
      ts_q <= ts_q + 1'b1;
      if (change) status_q <= status_i;
      if (change && full && !pop && drop_q != 16'hFFFF) drop_q <= drop_q + 1'b1;
    end
  end
  status_ev_fifo #(.WIDTH($bits(ev_rec_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (ev_in),
    .dout_o  (ev_out),
    .full_o  (full),
    .empty_o (empty)
  );
  assign ev_valid_o    = !empty;
  assign ev_status_o   = ev_out.status;
  assign ev_ts_o       = ev_out.ts;
  assign ev_drop_cnt_o = drop_q;
endmodule

// File: tb/tb_multicore_rst_status_mon.sv
// tb_multicore_rst_status_mon: randomized bench against a queue-based reference model
module tb_multicore_rst_status_mon;
  localparam int R = 100, S = 16, NC = 2, NS = 4, TW = 32, D = 8;
  logic clk = 0, rst = 1, ready = 0;
  logic [NS-1:0] status = '0;
  logic sys_rstn, ev_valid;
  logic [NC-1:0] core_rstn;
  logic [NS-1:0] ev_status;
  logic [TW-1:0] ev_ts;
  logic [15:0] drop;
  logic rst4 = 1, ready4 = 0, sys4, valid4;
  logic [NS-1:0] status4 = '0, st4;
  logic [2:0] core4;
  logic [3:0] ts4;
  logic [15:0] drop4;
  int checks = 0, errors = 0;
  int m_edge = 0, m_drop = 0;
  logic [NS-1:0] m_stat = '0;
  logic [NS+TW-1:0] m_q[$];

  multicore_rst_status_mon dut (
    .clk(clk), .rst(rst), .status_i(status), .sys_rstn_o(sys_rstn), .core_rstn_o(core_rstn),
    .ev_valid_o(ev_valid), .ev_ready_i(ready), .ev_status_o(ev_status), .ev_ts_o(ev_ts), .ev_drop_cnt_o(drop)
  );
  multicore_rst_status_mon #(.N_CORES(3), .RST_CYCLES(5), .STAGGER(0), .TS_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst4), .status_i(status4), .sys_rstn_o(sys4), .core_rstn_o(core4),
    .ev_valid_o(valid4), .ev_ready_i(ready4), .ev_status_o(st4), .ev_ts_o(ts4), .ev_drop_cnt_o(drop4)
  );

  always #5 clk = ~clk;

  function automatic logic exp_sys();
    return m_edge > R;
  endfunction

  function automatic logic [NC-1:0] exp_core();
    logic [NC-1:0] e;
    for (int k = 0; k < NC; k++) e[k] = m_edge > R + k * S;
    return e;
  endfunction

  // advance the reference model by one edge using the current inputs, then clock
  task automatic tick();
    int sz = m_q.size();
    bit pp = sz > 0 && ready;
    if (pp) void'(m_q.pop_front());
    if (status != m_stat) begin
      if (sz < D || pp) m_q.push_back({status, TW'(m_edge)});
      else if (m_drop < 65535) m_drop++;
      m_stat = status;
    end
    if (rst) begin
      m_q.delete();
      m_drop = 0;
      m_stat = '0;
      m_edge = 0;
    end else m_edge++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1;
    status = NS'($urandom);
    ready = 1'($urandom);
    tick();
    tick();
    checks++; if (sys_rstn !== 1'b0) begin errors++; $display("FAIL reset_sys: got %b want 0", sys_rstn); end
    checks++; if (core_rstn !== '0) begin errors++; $display("FAIL reset_core: got %b want 0", core_rstn); end
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ev_valid); end
    checks++; if (drop !== 16'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop); end
    checks++; if (ev_status !== '0 || ev_ts !== '0) begin errors++; $display("FAIL reset_ev: got %h/%h want 0/0", ev_status, ev_ts); end
  endtask

  task automatic test_sequencer();
    rst = 0;
    status = '0;
    ready = 1;
    repeat (130) begin
      tick();
      checks++; if (sys_rstn !== exp_sys()) begin errors++; $display("FAIL seq_sys edge %0d: got %b want %b", m_edge - 1, sys_rstn, exp_sys()); end
      checks++; if (core_rstn !== exp_core()) begin errors++; $display("FAIL seq_core edge %0d: got %b want %b", m_edge - 1, core_rstn, exp_core()); end
      checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL seq_no_event: got %b want 0", ev_valid); end
    end
  endtask

  task automatic test_single_event();
    while (m_edge < 200) tick();
    status = 4'b0101;
    tick();
    checks++; if (ev_valid !== 1'b1 || ev_status !== 4'd5 || ev_ts !== 32'd200) begin
      errors++; $display("FAIL single_event: got v=%b s=%h ts=%0d want v=1 s=5 ts=200", ev_valid, ev_status, ev_ts); end
    tick();
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL single_event_pop: got %b want 0", ev_valid); end
  endtask

  task automatic test_overflow();
    logic [NS-1:0] nv;
    ready = 0;
    for (int i = 0; i < 10; i++) begin
      do nv = NS'($urandom); while (nv == status);
      status = nv;
      tick();
    end
    checks++; if (drop !== 16'd2 || drop !== 16'(m_drop)) begin errors++; $display("FAIL overflow_drop: got %0d want 2", drop); end
    repeat (2) begin
      tick();
      checks++; if (ev_valid !== 1'b1 || {ev_status, ev_ts} !== m_q[0]) begin
        errors++; $display("FAIL overflow_hold: got %h/%h want %h", ev_status, ev_ts, m_q[0]); end
    end
  endtask

  task automatic test_full_push_pop();
    ready = 1;
    status = ~status;
    tick();
    checks++; if (drop !== 16'd2) begin errors++; $display("FAIL full_push_pop_drop: got %0d want 2", drop); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (ev_valid !== 1'b1 || {ev_status, ev_ts} !== m_q[0]) begin
        errors++; $display("FAIL drain_%0d: got v=%b %h/%h want %h", i, ev_valid, ev_status, ev_ts, m_q[0]); end
      tick();
    end
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b want 0", ev_valid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) status = NS'($urandom);
      ready = $urandom_range(0, 99) < 40;
      tick();
      checks++; if (ev_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL rand_valid %0d: got %b want %b", i, ev_valid, m_q.size() != 0); end
      if (m_q.size() != 0) begin
        checks++; if ({ev_status, ev_ts} !== m_q[0]) begin errors++; $display("FAIL rand_head %0d: got %h/%h want %h", i, ev_status, ev_ts, m_q[0]); end
      end
      checks++; if (drop !== 16'(m_drop)) begin errors++; $display("FAIL rand_drop %0d: got %0d want %0d", i, drop, m_drop); end
      checks++; if (sys_rstn !== 1'b1 || core_rstn !== '1) begin errors++; $display("FAIL rand_resets: got %b/%b want 1/11", sys_rstn, core_rstn); end
    end
  endtask

  task automatic test_first_edge();
    rst = 1;
    tick();
    rst = 0;
    ready = 0;
    status = 4'b1001;
    tick();
    checks++; if (ev_valid !== 1'b1 || ev_status !== 4'd9 || ev_ts !== 32'd0) begin
      errors++; $display("FAIL first_edge: got v=%b s=%h ts=%0d want v=1 s=9 ts=0", ev_valid, ev_status, ev_ts); end
  endtask

  task automatic test_midrun_reset();
    tick();
    status = 4'b0011;
    tick();
    status = 4'b1100;
    tick();
    while (m_edge < 108) tick();
    checks++; if (ev_valid !== 1'b1 || sys_rstn !== 1'b1) begin errors++; $display("FAIL pre_reset: got v=%b sys=%b want 1/1", ev_valid, sys_rstn); end
    rst = 1;
    status = '0;
    tick();
    checks++; if (sys_rstn !== 1'b0 || core_rstn !== '0) begin errors++; $display("FAIL midrun_resets: got %b/%b want 0/00", sys_rstn, core_rstn); end
    checks++; if (ev_valid !== 1'b0 || drop !== 16'd0) begin errors++; $display("FAIL midrun_fifo: got v=%b drop=%0d want 0/0", ev_valid, drop); end
    rst = 0;
    repeat (120) begin
      tick();
      checks++; if (sys_rstn !== exp_sys() || core_rstn !== exp_core()) begin
        errors++; $display("FAIL restart edge %0d: got %b/%b want %b/%b", m_edge - 1, sys_rstn, core_rstn, exp_sys(), exp_core()); end
    end
  endtask

  task automatic test_ts_wrap();
    rst4 = 1;
    tick();
    rst4 = 0;
    status4 = '0;
    ready4 = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (i == 4) begin
        checks++; if (sys4 !== 1'b0 || core4 !== 3'b000) begin errors++; $display("FAIL s0_before: got %b/%b want 0/000", sys4, core4); end
      end
      if (i == 5) begin
        checks++; if (sys4 !== 1'b1 || core4 !== 3'b111) begin errors++; $display("FAIL s0_release: got %b/%b want 1/111", sys4, core4); end
      end
    end
    status4 = 4'd1;
    tick();
    status4 = 4'd2;
    tick();
    checks++; if (valid4 !== 1'b1 || st4 !== 4'd1 || ts4 !== 4'd15) begin errors++; $display("FAIL wrap_first: got v=%b s=%h ts=%0d want 1/1/15", valid4, st4, ts4); end
    ready4 = 1;
    tick();
    checks++; if (valid4 !== 1'b1 || st4 !== 4'd2 || ts4 !== 4'd0) begin errors++; $display("FAIL wrap_second: got v=%b s=%h ts=%0d want 1/2/0", valid4, st4, ts4); end
    tick();
    checks++; if (valid4 !== 1'b0 || drop4 !== 16'd0) begin errors++; $display("FAIL wrap_empty: got v=%b drop=%0d want 0/0", valid4, drop4); end
  endtask

  initial begin
    test_reset();
    test_sequencer();
    test_single_event();
    test_overflow();
    test_full_push_pop();
    test_random();
    test_first_edge();
    test_midrun_reset();
    test_ts_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicore_rst_status_mon.md
MULTICORE_RST_STATUS_MON -- requirements
Module: multicore_rst_status_mon

Interface
REQ-001 SHALL have parameter N_CORES, default 2, number of staggered core reset outputs (1..8).
REQ-002 SHALL have parameter RST_CYCLES, default 100, cycles from reset deassertion until sys_rstn_o releases.
REQ-003 SHALL have parameter STAGGER, default 16, cycles between successive core reset releases (0 allowed).
REQ-004 SHALL have parameter N_STATUS, default 4, width of the monitored status (LED) vector.
REQ-005 SHALL have parameter TS_WIDTH, default 32, timestamp width.
REQ-006 SHALL have parameter FIFO_DEPTH, default 8, event FIFO entries (power of 2, >=2).
REQ-007 SHALL have port clk, input, 1, single clock; all logic is clocked on its rising edge.
REQ-008 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-009 SHALL have port status_i, input, N_STATUS, monitored status vector (synchronous to clk).
REQ-010 SHALL have port sys_rstn_o, output, 1, active-low system reset.
REQ-011 SHALL have port core_rstn_o, output, N_CORES, active-low per-core resets.
REQ-012 SHALL have port ev_valid_o, output, 1, event available.
REQ-013 SHALL have port ev_ready_i, input, 1, consumer accepts event.
REQ-014 SHALL have port ev_status_o, output, N_STATUS, new status value of the head event.
REQ-015 SHALL have port ev_ts_o, output, TS_WIDTH, timestamp of the head event.
REQ-016 SHALL have port ev_drop_cnt_o, output, 16, count of dropped events.

Function
REQ-017 SHALL run sequencer states HOLD -> STAGGER -> RUN; RUN is terminal until rst.
REQ-018 SHALL increment a sequencer counter from 0 each cycle in HOLD/STAGGER; it stops in RUN.
REQ-019 SHALL drive sys_rstn_o to 1 from the edge at which the counter equals RST_CYCLES, entering STAGGER.
REQ-020 SHALL drive core_rstn_o[k] to 1 from the edge at which the counter equals RST_CYCLES+k*STAGGER; with STAGGER=0, all cores release on the same edge as sys_rstn_o.
REQ-021 SHALL enter RUN on the edge that releases core N_CORES-1; released resets never re-assert except via rst.
REQ-022 SHALL keep a free-running timestamp counter: 0 on the first edge after rst deasserts, +1 per cycle, wrapping modulo 2^TS_WIDTH.
REQ-023 SHALL hold a registered copy status_r; on each edge where status_i != status_r, status_r <= status_i and one event {status_i, current timestamp} is pushed.
REQ-024 SHALL detect changes in all sequencer states (monitoring is independent of core reset state).
REQ-025 SHALL make an event visible on ev_valid_o/ev_status_o/ev_ts_o one cycle after the sampling edge (show-ahead head).
REQ-026 SHALL pop the head on an edge where ev_valid_o && ev_ready_i; ev_* outputs remain stable while ev_valid_o && !ev_ready_i.
REQ-027 SHALL, when FIFO is full and no pop occurs, drop the new event, still update status_r, and increment ev_drop_cnt_o, saturating at 0xFFFF.
REQ-028 SHALL, when full with simultaneous pop and push, accept the push (no drop).
REQ-029 SHALL, when empty with a push, not bypass: ev_valid_o rises on the following cycle.
REQ-030 SHALL treat ev_ready_i as don't-care while ev_valid_o is 0.

Reset
REQ-031 SHALL on rst: sys_rstn_o=0, core_rstn_o=all 0, sequencer counter=0, state=HOLD.
REQ-032 SHALL on rst: timestamp=0, status_r=0, FIFO empty (ev_valid_o=0), ev_drop_cnt_o=0, ev_status_o=0, ev_ts_o=0.
REQ-033 SHALL, on rst asserted mid-operation, discard all pending events and re-assert all reset outputs on the same edge.
REQ-034 SHALL, on the first edge after rst with status_i nonzero, push an event with timestamp 0.

Structure
REQ-035 SHALL place the event record typedef (status, timestamp) and sequencer state enum in shared package rst_status_mon_pkg; field widths follow the module parameters, with package defaults matching REQ-004/REQ-005.
REQ-036 SHALL implement the event buffer as sub-module status_ev_fifo (synchronous, show-ahead, full/empty flags, parametrised width/depth).
REQ-037 SHALL contain no initial blocks, delays, or simulation-only constructs; fully synthesisable.

Verification
REQ-038 Default parameters, status_i=0 throughout -> sys_rstn_o rises after edge 100, core_rstn_o[0] same edge, core_rstn_o[1] after edge 116; no events.
REQ-039 status_i 0->4'b0101 sampled at timestamp 200, ev_ready_i=1 -> ev_valid_o one cycle later with ev_status_o=5, ev_ts_o=200, single-cycle valid.
REQ-040 ev_ready_i=0, status toggles 10 times on consecutive cycles -> 8 events retained in order, ev_drop_cnt_o=2, final status_r matches last input.
REQ-041 FIFO full, ev_ready_i=1 on the same edge as a new change -> no drop, count stays 8, ev_drop_cnt_o unchanged.
REQ-042 TS_WIDTH=4, change at timestamp 15 then at next cycle -> ev_ts_o values 15 then 0.
REQ-043 rst asserted at cycle 108 with 3 queued events -> next edge: all resets low, ev_valid_o=0, ev_drop_cnt_o=0; sequence restarts from 0.
